// File: rtl/uart_seq_pkg.sv
// Shared declarations for uart_tx_sequencer: FSM states, UART register map, status bits, commands.
// Latency: none (types and constants only).
// Backpressure: none.
package uart_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_BAUD,
      S_WR_EN,
      S_WR_MASK,
      S_POLL,
      S_WR_DATA,
      S_WR_GO,
      S_DRAIN,
      S_WR_STOP,
      S_WR_DIS
   } state_e;

   // Peripheral register addresses
   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_INTMASK = 2'd1;
   localparam logic [1:0] REG_DATA    = 2'd2;
   localparam logic [1:0] REG_BAUD    = 2'd3;

   // Status register bit positions
   localparam int ST_EN     = 0;
   localparam int ST_GO     = 1;
   localparam int ST_FULL   = 2;
   localparam int ST_TXBUSY = 3;

   // Values written to the status register
   localparam logic [7:0] CMD_DIS = 8'h00;
   localparam logic [7:0] CMD_EN  = 8'h01;
   localparam logic [7:0] CMD_GO  = 8'h03;

endpackage

// File: rtl/cpu_bus_access.sv
// Two-cycle CPU bus engine: STROBE (NCS low, NO or NW low) then RECOVER (bus released).
// Latency: strobe starts the edge after req_i is seen while free; ack_o is high for the whole STROBE cycle.
// Backpressure: req_i is ignored while a STROBE is in flight; the caller holds req_i until ack_o.
module cpu_bus_access (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   input  logic       wr_i,
   input  logic [1:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       start_o,
   output logic       ack_o,
   output logic [7:0] rdata_o,
   input  logic [7:0] din_i,
   output logic [1:0] addr_o,
   output logic       ncs_o,
   output logic       no_o,
   output logic       nw_o,
   output logic [7:0] dout_o,
   output logic       doe_o
);

   logic       strobe_q, strobe_d;
   logic [1:0] addr_q, addr_d;
   logic       ncs_q, ncs_d, no_q, no_d, nw_q, nw_d, doe_q, doe_d;
   logic [7:0] dout_q, dout_d;

   // The caller samples rdata_o on the edge that ends STROBE, i.e. while ack_o is high
   assign start_o = req_i & ~strobe_q;
   assign ack_o   = strobe_q;
   assign rdata_o = din_i;

   // Launch a STROBE when free and requested; always release the bus after one STROBE cycle
   always_comb begin
      strobe_d = 1'b0;
      addr_d   = addr_q;
      dout_d   = dout_q;
      ncs_d    = 1'b1;
      no_d     = 1'b1;
      nw_d     = 1'b1;
      doe_d    = 1'b0;
      if (start_o) begin
         strobe_d = 1'b1;
         addr_d   = addr_i;
         ncs_d    = 1'b0;
         no_d     = wr_i;
         nw_d     = ~wr_i;
         doe_d    = wr_i;
         if (wr_i) begin
            dout_d = wdata_i;
         end
      end
   end

   // Bus pin registers; reset releases the bus immediately
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         strobe_q <= 1'b0;
         addr_q   <= 2'd0;
         dout_q   <= 8'h00;
         ncs_q    <= 1'b1;
         no_q     <= 1'b1;
         nw_q     <= 1'b1;
         doe_q    <= 1'b0;
      end else begin
         strobe_q <= strobe_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         ncs_q    <= ncs_d;
         no_q     <= no_d;
         nw_q     <= nw_d;
         doe_q    <= doe_d;
      end
   end

   assign addr_o = addr_q;
   assign ncs_o  = ncs_q;
   assign no_o   = no_q;
   assign nw_o   = nw_q;
   assign dout_o = dout_q;
   assign doe_o  = doe_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Bus master that configures the UART and streams source bytes into its TX FIFO in batches of up to FIFO_DEPTH.
// Latency: start at edge 0 -> first data STROBE in cycle 9; steady state one byte per 4 cycles.
// Backpressure: src_ready pulses once per accepted byte; FIFO-full status or src_valid low keeps it polling.
// Build option UART_SEQ_IRQ_WAIT_EN: DRAIN waits for NINT low on 2 consecutive cycles instead of polling status.
module uart_tx_sequencer
   import uart_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       CLK,
   input  logic       NRST,
   input  logic       start,
   input  logic [7:0] baud_div,
   input  logic [7:0] int_mask,
   input  logic       src_valid,
   input  logic [7:0] src_data,
   input  logic       src_last,
   output logic       src_ready,
   output logic [1:0] ADDR,
   output logic       NCS,
   output logic       NO,
   output logic       NW,
   output logic [7:0] DATA_OUT,
   output logic       DATA_OE,
   input  logic [7:0] DATA_IN,
   input  logic       NINT,
   output logic       busy,
   output logic       done
);

   localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

   state_e     state_q, state_d;
   logic [4:0] count_q, count_d;
   logic       last_q, last_d;
   logic [7:0] baud_q, baud_d, mask_q, mask_d;
   logic       busy_q, done_q, src_ready_q;

   logic       bus_req, bus_wr, bus_start, bus_ack;
   logic [1:0] bus_addr;
   logic [7:0] bus_wdata, rd_dat;

   // Status bits the FSM never inspects, and NINT in the polling build
   logic unused_inputs;
   assign unused_inputs = ^{rd_dat[7:4], rd_dat[3], rd_dat[1:0], NINT};

`ifdef UART_SEQ_IRQ_WAIT_EN
   logic nint_low_q;

   // Remember NINT was low last cycle while draining, so two consecutive lows end the drain
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         nint_low_q <= 1'b0;
      end else begin
         nint_low_q <= (state_q == S_DRAIN) & ~NINT;
      end
   end
`endif

   // Next state and the single bus request each state issues
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      last_d    = last_q;
      baud_d    = baud_q;
      mask_d    = mask_q;
      bus_req   = 1'b0;
      bus_wr    = 1'b1;
      bus_addr  = REG_STATUS;
      bus_wdata = CMD_DIS;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               baud_d  = baud_div;
               mask_d  = int_mask;
               state_d = S_WR_BAUD;
            end
         end
         S_WR_BAUD: begin
            bus_req   = 1'b1;
            bus_addr  = REG_BAUD;
            bus_wdata = baud_q;
            if (bus_ack) state_d = S_WR_EN;
         end
         S_WR_EN: begin
            bus_req   = 1'b1;
            bus_wdata = CMD_EN;
            if (bus_ack) state_d = S_WR_MASK;
         end
         S_WR_MASK: begin
            bus_req   = 1'b1;
            bus_addr  = REG_INTMASK;
            bus_wdata = mask_q;
            if (bus_ack) state_d = S_POLL;
         end
         S_POLL: begin
            bus_req = 1'b1;
            bus_wr  = 1'b0;
            if (bus_ack && !rd_dat[ST_FULL] && src_valid) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            bus_req   = 1'b1;
            bus_addr  = REG_DATA;
            bus_wdata = src_data;
            if (bus_ack) begin
               count_d = count_q + 5'd1;
               if (src_last || (count_d == DEPTH_C)) begin
                  last_d  = src_last;
                  state_d = S_WR_GO;
               end else begin
                  state_d = S_POLL;
               end
            end
         end
         S_WR_GO: begin
            bus_req   = 1'b1;
            bus_wdata = CMD_GO;
            if (bus_ack) begin
               count_d = 5'd0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
`ifdef UART_SEQ_IRQ_WAIT_EN
            if (!NINT && nint_low_q) state_d = S_WR_STOP;
`else
            bus_req = 1'b1;
            bus_wr  = 1'b0;
            if (bus_ack && !rd_dat[ST_TXBUSY]) state_d = S_WR_STOP;
`endif
         end
         S_WR_STOP: begin
            bus_req   = 1'b1;
            bus_wdata = CMD_EN;
            if (bus_ack) state_d = last_q ? S_WR_DIS : S_POLL;
         end
         S_WR_DIS: begin
            bus_req   = 1'b1;
            bus_wdata = CMD_DIS;
            if (bus_ack) begin
               last_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, batch bookkeeping and registered handshake/status outputs
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q     <= S_IDLE;
         count_q     <= 5'd0;
         last_q      <= 1'b0;
         baud_q      <= 8'h00;
         mask_q      <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         src_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         last_q      <= last_d;
         baud_q      <= baud_d;
         mask_q      <= mask_d;
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_q == S_WR_DIS) & bus_ack;
         src_ready_q <= (state_q == S_WR_DATA) & bus_start;
      end
   end

   cpu_bus_access u_bus (
      .clk_i   (CLK),
      .rst_ni  (NRST),
      .req_i   (bus_req),
      .wr_i    (bus_wr),
      .addr_i  (bus_addr),
      .wdata_i (bus_wdata),
      .start_o (bus_start),
      .ack_o   (bus_ack),
      .rdata_o (rd_dat),
      .din_i   (DATA_IN),
      .addr_o  (ADDR),
      .ncs_o   (NCS),
      .no_o    (NO),
      .nw_o    (NW),
      .dout_o  (DATA_OUT),
      .doe_o   (DATA_OE)
   );

   assign src_ready = src_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: UART register-port model, byte source, and transfer-level reference checks.
// Latency: n/a.
// Backpressure: the source holds each byte until src_ready; optional random gaps between bytes.
module tb_uart_tx_sequencer;

   logic       CLK = 1'b0;
   logic       NRST = 1'b0;
   logic       start = 1'b0;
   logic [7:0] baud_div = 8'h00, int_mask = 8'h00;
   logic       src_valid = 1'b0, src_last = 1'b0;
   logic [7:0] src_data = 8'h00;
   logic       src_ready, NCS, NO, NW, DATA_OE, busy, done;
   logic [1:0] ADDR;
   logic [7:0] DATA_OUT;
   logic [7:0] DATA_IN = 8'h00;
   logic       NINT = 1'b1;

   uart_tx_sequencer #(.FIFO_DEPTH(16)) dut (
      .CLK(CLK), .NRST(NRST), .start(start), .baud_div(baud_div), .int_mask(int_mask),
      .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
      .ADDR(ADDR), .NCS(NCS), .NO(NO), .NW(NW), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
      .DATA_IN(DATA_IN), .NINT(NINT), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- byte source (holds valid until accepted) ----------------
   logic [8:0] src_buf [0:255];
   int  src_tail = 0;    // written by the stimulus
   int  src_flush = 0;   // written by the stimulus
   bit  stall_en = 1'b0; // written by the stimulus
   int  src_head = 0;
   int  stall_left = 0;
   logic fd_sr;

   always begin
      @(negedge CLK);
      fd_sr = src_ready;
      @(posedge CLK);
      #1;
      if (fd_sr && src_head < src_tail) begin
         src_head++;
         if (stall_en) stall_left = $urandom_range(0, 3);
      end
      if (src_head < src_flush) begin
         src_head   = src_flush;
         stall_left = 0;
      end
      if (stall_left > 0) begin
         src_valid = 1'b0;
         stall_left--;
      end else if (src_head < src_tail) begin
         src_valid = 1'b1;
         src_data  = src_buf[src_head][7:0];
         src_last  = src_buf[src_head][8];
      end else begin
         src_valid = 1'b0;
         src_data  = 8'h00;
         src_last  = 1'b0;
      end
   end

   // ---------------- peripheral model and bus monitor ----------------
   typedef struct {
      bit         wr;
      logic [1:0] addr;
      logic [7:0] dat;
      int         cyc;
   } acc_t;

   acc_t acc_q[$];
   int   dk_q[$];           // drain delay chosen for each GO
   int   full_hold_v = 0, full_gen = 0, mdl_rst_gen = 0;  // written by the stimulus
   int   full_gen_seen = 0, mdl_gen_seen = 0;
   int   full_left = 0, busy_left = 0, nint_wait = 0, nint_low = 0;
   int   rdy_cnt = 0, done_cnt = 0, viol = 0;
   bit   en_b = 1'b0, go_b = 1'b0;

   always @(negedge CLK) begin
      acc_t e;
      int   k;
      if (mdl_gen_seen != mdl_rst_gen) begin
         mdl_gen_seen = mdl_rst_gen;
         full_left = 0; busy_left = 0; nint_wait = 0; nint_low = 0;
         en_b = 1'b0; go_b = 1'b0;
      end
      if (full_gen_seen != full_gen) begin
         full_gen_seen = full_gen;
         full_left     = full_hold_v;
      end
      if (!NO && !NW) viol++;
      if (DATA_OE && NW) viol++;
      if (src_ready) rdy_cnt++;
      if (done) done_cnt++;
      if (!NCS) begin
         e.wr   = !NW;
         e.addr = ADDR;
         e.cyc  = cyc;
         if (!NW) begin
            e.dat = DATA_OUT;
            if (ADDR == 2'd0) begin
               en_b = DATA_OUT[0];
               go_b = DATA_OUT[1];
               if (DATA_OUT == 8'h03) begin
                  k = $urandom_range(0, 3);
                  dk_q.push_back(k);
`ifdef UART_SEQ_IRQ_WAIT_EN
                  nint_wait = k + 3;
`else
                  busy_left = k;
`endif
               end
            end
         end else begin
            e.dat   = {4'b0000, busy_left > 0, full_left > 0, go_b, en_b};
            DATA_IN = e.dat;
            if (full_left > 0) full_left--;
            if (busy_left > 0) busy_left--;
         end
         acc_q.push_back(e);
      end
`ifdef UART_SEQ_IRQ_WAIT_EN
      if (nint_low > 0) begin
         NINT = 1'b0;
         nint_low--;
      end else begin
         NINT = 1'b1;
         if (nint_wait > 0) begin
            nint_wait--;
            if (nint_wait == 0) nint_low = 2;
         end
      end
`endif
   end

   // ---------------- one complete transfer against the reference ----------------
   task automatic run_xfer(input string tag, input logic [7:0] baud, input logic [7:0] mask,
                           input int nbytes, input bit fixed, input bit stalls,
                           input int full_hold, input bit lat_chk);
      acc_t exp_w[$];
      acc_t got_w[$];
      acc_t w;
      logic [7:0] b;
      int base, dbase, done0, rdy0, viol0, e_edge, t, bad, n, j, batch, polls, first_d;
      base  = acc_q.size();
      dbase = dk_q.size();
      done0 = done_cnt;
      rdy0  = rdy_cnt;
      viol0 = viol;

      // Reference: register setup, data in batches of at most 16, GO/STOP per batch, then disable
      w.wr = 1'b1; w.cyc = 0;
      w.addr = 2'd3; w.dat = baud; exp_w.push_back(w);
      w.addr = 2'd0; w.dat = 8'h01; exp_w.push_back(w);
      w.addr = 2'd1; w.dat = mask; exp_w.push_back(w);
      batch = 0;
      for (int i = 0; i < nbytes; i++) begin
         if (fixed) b = 8'hA1 + 8'(i) * 8'h11;
         else b = 8'($urandom);
         src_buf[src_tail + i] = {(i == nbytes - 1), b};
         w.addr = 2'd2; w.dat = b; exp_w.push_back(w);
         batch++;
         if (i == nbytes - 1 || batch == 16) begin
            w.addr = 2'd0; w.dat = 8'h03; exp_w.push_back(w);
            w.addr = 2'd0; w.dat = 8'h01; exp_w.push_back(w);
            batch = 0;
         end
      end
      w.addr = 2'd0; w.dat = 8'h00; exp_w.push_back(w);

      stall_en    = stalls;
      full_hold_v = full_hold;
      full_gen++;
      src_tail    = src_tail + nbytes;
      repeat (2) @(posedge CLK);
      #1;
      start = 1'b1; baud_div = baud; int_mask = mask;
      e_edge = cyc + 1;
      @(negedge CLK);
      if (lat_chk) chk({tag, ".busy_before"}, busy, 1'b0);
      @(negedge CLK);
      chk({tag, ".busy_after_start"}, busy, 1'b1);
      start = 1'b0;
      repeat (10) @(negedge CLK);
      start = 1'b1; baud_div = ~baud; int_mask = ~mask;   // must be ignored while busy
      @(negedge CLK);
      start = 1'b0;

      t = 0;
      while (done_cnt == done0 && t < 4000) begin
         @(negedge CLK);
         t++;
      end
      chk({tag, ".done_in_time"}, done_cnt > done0, 1'b1);
      repeat (5) @(negedge CLK);
      chk({tag, ".done_pulses"}, done_cnt - done0, 1);
      chk({tag, ".ready_pulses"}, rdy_cnt - rdy0, nbytes);
      chk({tag, ".busy_end"}, busy, 1'b0);
      chk({tag, ".pin_rules"}, viol - viol0, 0);

      for (int i = base; i < acc_q.size(); i++) if (acc_q[i].wr) got_w.push_back(acc_q[i]);
      chk({tag, ".n_writes"}, got_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
         chk($sformatf("%s.write%0d", tag, i), {got_w[i].addr, got_w[i].dat}, {exp_w[i].addr, exp_w[i].dat});

      // Every data write follows a status read that reported not-full; reads only target status
      bad = 0;
      for (int i = base; i < acc_q.size(); i++) begin
         if (!acc_q[i].wr && acc_q[i].addr != 2'd0) bad++;
         if (acc_q[i].wr && acc_q[i].addr == 2'd2)
            if (i == base || acc_q[i-1].wr || acc_q[i-1].dat[2]) bad++;
      end
      chk({tag, ".poll_before_data"}, bad, 0);

      // Drain: reads after each GO equal busy polls + 1 (none when waiting on the interrupt)
      bad = 0;
      j = dbase;
      for (int i = base; i < acc_q.size(); i++) begin
         if (acc_q[i].wr && acc_q[i].addr == 2'd0 && acc_q[i].dat == 8'h03) begin
            n = 0;
            for (int m = i + 1; m < acc_q.size() && !acc_q[m].wr; m++) n++;
`ifdef UART_SEQ_IRQ_WAIT_EN
            if (n != 0) bad++;
`else
            if (j >= dk_q.size() || n != dk_q[j] + 1) bad++;
`endif
            j++;
         end
      end
      chk({tag, ".drain_reads"}, bad, 0);

      first_d = -1;
      for (int i = base; i < acc_q.size() && first_d < 0; i++)
         if (acc_q[i].wr && acc_q[i].addr == 2'd2) first_d = i;
      if (!stalls) begin
         polls = 0;
         for (int i = base + 3; i < first_d; i++) if (!acc_q[i].wr) polls++;
         chk({tag, ".polls_before_first_data"}, polls, full_hold + 1);
      end
      if (lat_chk) begin
         chk({tag, ".baud_strobe_cycle"}, acc_q[base].cyc, e_edge + 1);
         chk({tag, ".first_data_cycle"}, (first_d < 0) ? -1 : acc_q[first_d].cyc, e_edge + 9);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t, base;
      NRST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst.ADDR", ADDR, 2'd0);
      chk("rst.NCS", NCS, 1'b1);
      chk("rst.NO", NO, 1'b1);
      chk("rst.NW", NW, 1'b1);
      chk("rst.DATA_OUT", DATA_OUT, 8'h00);
      chk("rst.DATA_OE", DATA_OE, 1'b0);
      chk("rst.src_ready", src_ready, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      NRST = 1'b1;
      repeat (2) @(negedge CLK);

      run_xfer("basic", 8'h0C, 8'h08, 3, 1'b1, 1'b0, 0, 1'b1);
      run_xfer("twenty", 8'($urandom), 8'($urandom), 20, 1'b0, 1'b1, 0, 1'b0);
      run_xfer("fullhold", 8'($urandom), 8'($urandom), 5, 1'b0, 1'b0, 10, 1'b0);

      // Reset in the middle of a data-register STROBE
      src_buf[src_tail]     = 9'h011;
      src_buf[src_tail + 1] = 9'h122;
      src_tail = src_tail + 2;
      stall_en = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      start = 1'b1; baud_div = 8'h05; int_mask = 8'h08;
      @(negedge CLK);
      @(negedge CLK);
      start = 1'b0;
      t = 0;
      while (!(!NCS && !NW && ADDR == 2'd2) && t < 300) begin
         @(negedge CLK);
         t++;
      end
      chk("rstmid.reached_data_strobe", (!NCS && !NW && ADDR == 2'd2), 1'b1);
      #2;
      NRST = 1'b0;
      #1;
      chk("rstmid.NCS", NCS, 1'b1);
      chk("rstmid.NW", NW, 1'b1);
      chk("rstmid.NO", NO, 1'b1);
      chk("rstmid.DATA_OE", DATA_OE, 1'b0);
      chk("rstmid.busy", busy, 1'b0);
      src_flush = src_tail;
      mdl_rst_gen++;
      @(posedge CLK);
      @(negedge CLK);
      NRST = 1'b1;
      base = acc_q.size();
      repeat (20) @(negedge CLK);
      chk("rstmid.no_bus_activity", acc_q.size() - base, 0);
      chk("rstmid.idle_busy", busy, 1'b0);
      chk("rstmid.idle_NCS", NCS, 1'b1);

      run_xfer("sixteen", 8'($urandom), 8'($urandom), 16, 1'b0, 1'b0, 0, 1'b0);
      run_xfer("random", 8'($urandom), 8'($urandom), $urandom_range(1, 40), 1'b0, 1'b1,
               $urandom_range(0, 4), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
